mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage consumer of the EX/MEM pipeline register outputs (load_store_info, regdata2, alu_result).
//  Turns a load/store into a valid/ready data-bus transaction, waits for the response, and aligns
//  and extends load data for the MEM/WB register. Stalls the pipeline while a transaction is in flight.
// PARAMETERS
//  ADDR_W   64   data-bus address width (alu_result is 64-bit, low ADDR_W bits used)
//  LS_W     11   width of load_store_info one-hot vector
// PORTS
//  clk               in   1      clock
//  rst               in   1      reset: synchronous, active-high
//  regM_i_ls_info    in   LS_W   one-hot {sd,sw,sh,sb,lwu,lhu,lbu,ld,lw,lh,lb} (bit10..bit0); 0 = no access
//  regM_i_regdata2   in   64     store data (rs2)
//  regM_i_alu_result in   64     effective address
//  ext_hold_i        in   1      downstream pipeline stalled for other reasons
//  dbus_req_valid    out  1      request valid
//  dbus_req_ready    in   1      request accepted when valid&ready
//  dbus_req_addr     out  ADDR_W doubleword-aligned address {addr[ADDR_W-1:3],3'b0}
//  dbus_req_wen      out  1      1 = store
//  dbus_req_wdata    out  64     lane-replicated store data
//  dbus_req_wstrb    out  8      byte strobes (0 for loads)
//  dbus_resp_valid   in   1      response/ack valid (one cycle)
//  dbus_resp_rdata   in   64     raw doubleword read data
//  mem_o_stall       out  1      freeze IF..EX/MEM while high
//  mem_o_rdata       out  64     aligned, extended load result
//  mem_o_done        out  1      one-cycle pulse: access complete, mem_o_rdata valid
// BEHAVIOUR
//  Reset: state IDLE; dbus_req_valid=0, wen=0, wstrb=0, addr=0, wdata=0; stall=0, rdata=0, done=0.
//  FSM IDLE -> REQ -> WAIT -> DONE -> IDLE.
//   IDLE: ls_info==0 -> stay, stall=0. ls_info!=0 -> REQ; stall combinationally 1 that same cycle.
//   REQ : req_valid=1; addr/wen/wdata/wstrb registered at IDLE->REQ and held stable until handshake.
//         valid&ready -> WAIT (valid drops next cycle). No ready -> stay in REQ, indefinitely.
//   WAIT: req_valid=0; resp_valid -> capture aligned rdata, -> DONE. resp_valid outside WAIT ignored.
//   DONE: stall=0, done=1. ext_hold_i=0 -> IDLE. ext_hold_i=1 -> stay DONE with stall=0, done=0
//         after first cycle, rdata held; prevents re-issuing the same held instruction.
//  Stores also wait for resp_valid (ack); mem_o_rdata unchanged on stores.
//  Strobes (o = addr[2:0]): sb 8'h01<<o; sh 8'h03<<o; sw 8'h0F<<o; sd 8'hFF.
//  wdata: sb {8{d[7:0]}}, sh {4{d[15:0]}}, sw {2{d[31:0]}}, sd d.
//  Load align: shift rdata right by 8*o, then lb/lh/lw sign-extend, lbu/lhu/lwu zero-extend, ld as-is.
//  Multiple ls_info bits set: illegal; no request, treated as ls_info==0.
//  rst in any state: next cycle IDLE, req_valid=0; any late response is dropped (bus must tolerate).
// CONFIGURATION
//  MEM_MISALIGN_TRAP_EN defined: lh/lhu/sh with o[0]!=0, word with o[1:0]!=0, dword with o!=0 -> no
//   bus request; IDLE -> DONE directly; extra output mem_o_misalign (1) pulses with done; rdata unchanged.
//  Not defined: no check, no mem_o_misalign port; o forced to access-size alignment
//   (low 1/2/3 bits cleared for half/word/dword) before strobe/align computation.
// STRUCTURE
//  Package mem_pkg: LS_* one-hot bit indices, ls_info width, FSM state enum (2-bit).
//  Sub-module load_align: combinational (raw rdata, offset, ls_info) -> extended 64-bit result.
//  Top: FSM, request registers, strobe/wdata generation, result register.
// TESTING
//  lw @0x1004, resp_rdata 0x8000_0001_xxxx_xxxx -> wstrb=0, addr 0x1000, rdata 0xFFFF_FFFF_8000_0001, done 1 cycle.
//  lbu @0x2007, rdata[63:56]=0xF0 -> rdata 0x0000_0000_0000_00F0; lb same -> 0xFFFF_FFFF_FFFF_FFF0.
//  sh @0x3002 data 0x1234 -> wen=1, wstrb 8'h0C, wdata 0x1234_1234_1234_1234; stall until ack+1.
//  sd with req_ready low 3 cycles -> req_valid held 4 cycles, addr/wdata stable, single handshake.
//  rst asserted in WAIT, resp_valid arrives 2 cycles later -> stays IDLE, done never pulses.
//  MEM_MISALIGN_TRAP_EN: lw @0x1006 -> no req_valid, misalign+done same cycle, stall 1 cycle only.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared constants, types and decode helpers for the MEM-stage access unit
//
// Purpose: one-hot load/store bit positions, FSM state encodings and small decode
// functions used by mem_access_unit and load_align.
// Ports: none (package).
// Config macro: MEM_MISALIGN_TRAP_EN (consumers use ls_misaligned only when defined).

package mem_pkg;

  localparam int LS_INFO_W = 11;

  // One-hot bit positions inside load_store_info.
  localparam int LS_LB  = 0;
  localparam int LS_LH  = 1;
  localparam int LS_LW  = 2;
  localparam int LS_LD  = 3;
  localparam int LS_LBU = 4;
  localparam int LS_LHU = 5;
  localparam int LS_LWU = 6;
  localparam int LS_SB  = 7;
  localparam int LS_SH  = 8;
  localparam int LS_SW  = 9;
  localparam int LS_SD  = 10;

  // FSM states (2-bit encodings kept as plain constants).
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } acc_size_e;

  // Exactly one bit set; zero or several bits means "no access".
  function automatic logic ls_legal(input logic [LS_INFO_W-1:0] ls);
    return (ls != '0) && ((ls & (ls - 1'b1)) == '0);
  endfunction

  function automatic logic ls_is_store(input logic [LS_INFO_W-1:0] ls);
    return ls[LS_SB] | ls[LS_SH] | ls[LS_SW] | ls[LS_SD];
  endfunction

  function automatic acc_size_e ls_size(input logic [LS_INFO_W-1:0] ls);
    if (ls[LS_LD] | ls[LS_SD])
      return SZ_D;
    else if (ls[LS_LW] | ls[LS_LWU] | ls[LS_SW])
      return SZ_W;
    else if (ls[LS_LH] | ls[LS_LHU] | ls[LS_SH])
      return SZ_H;
    else
      return SZ_B;
  endfunction

  // Clear the offset bits below the access size.
  function automatic logic [2:0] align_off(input acc_size_e sz, input logic [2:0] o);
    case (sz)
      SZ_H:    return {o[2:1], 1'b0};
      SZ_W:    return {o[2], 2'b00};
      SZ_D:    return 3'b000;
      default: return o;
    endcase
  endfunction

  function automatic logic ls_misaligned(input acc_size_e sz, input logic [2:0] o);
    case (sz)
      SZ_H:    return o[0];
      SZ_W:    return |o[1:0];
      SZ_D:    return |o;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_load_align.sv
// rtl/mem_access_unit_load_align.sv - shift raw doubleword to the access offset and extend
//
// Purpose: combinational load-data alignment for the MEM stage.
// Ports:
//   raw       in  64  raw doubleword from the data bus
//   offset    in  3   byte offset inside the doubleword
//   load_sel  in  7   load bits of load_store_info {lwu,lhu,lbu,ld,lw,lh,lb}
//   result    out 64  aligned, sign/zero-extended load value (0 if no load bit set)

module load_align
  import mem_pkg::*;
(
  input  logic [63:0] raw,
  input  logic [2:0]  offset,
  input  logic [6:0]  load_sel,
  output logic [63:0] result
);

  logic [63:0] shifted;

  assign shifted = raw >> {offset, 3'b000};

  always_comb begin
    result = '0;
    if (load_sel[LS_LB])
      result = {{56{shifted[7]}}, shifted[7:0]};
    else if (load_sel[LS_LH])
      result = {{48{shifted[15]}}, shifted[15:0]};
    else if (load_sel[LS_LW])
      result = {{32{shifted[31]}}, shifted[31:0]};
    else if (load_sel[LS_LD])
      result = shifted;
    else if (load_sel[LS_LBU])
      result = {56'd0, shifted[7:0]};
    else if (load_sel[LS_LHU])
      result = {48'd0, shifted[15:0]};
    else if (load_sel[LS_LWU])
      result = {32'd0, shifted[31:0]};
  end

endmodule

// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - MEM-stage load/store to valid/ready data-bus bridge
//
// Purpose: issues one bus transaction per load/store from EX/MEM, waits for the
// response, aligns/extends load data, and stalls the pipeline while in flight.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   regM_i_ls_info/regdata2/alu_result   EX/MEM outputs (one-hot op, store data, address)
//   ext_hold_i                    downstream stall from elsewhere in the pipeline
//   dbus_req_*                    request channel (valid/ready, addr, wen, wdata, wstrb)
//   dbus_resp_valid/rdata         one-cycle response / store ack
//   mem_o_stall                   freeze IF..EX/MEM
//   mem_o_rdata, mem_o_done       load result and one-cycle completion pulse
//   mem_o_misalign                only with MEM_MISALIGN_TRAP_EN: misaligned access trap
// Config macro: MEM_MISALIGN_TRAP_EN enables the misalignment trap; otherwise the
// offset is silently rounded down to the access size.

module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int LS_W   = LS_INFO_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [LS_W-1:0]   regM_i_ls_info,
  input  logic [63:0]       regM_i_regdata2,
  input  logic [63:0]       regM_i_alu_result,
  input  logic              ext_hold_i,
  output logic              dbus_req_valid,
  input  logic              dbus_req_ready,
  output logic [ADDR_W-1:0] dbus_req_addr,
  output logic              dbus_req_wen,
  output logic [63:0]       dbus_req_wdata,
  output logic [7:0]        dbus_req_wstrb,
  input  logic              dbus_resp_valid,
  input  logic [63:0]       dbus_resp_rdata,
  output logic              mem_o_stall,
  output logic [63:0]       mem_o_rdata,
  output logic              mem_o_done
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic              mem_o_misalign
`endif
);

  logic [1:0]      state;
  logic [1:0]      state_nxt;
  logic [LS_W-1:0] ls_r;
  logic [2:0]      off_r;
  logic            ls_ok;
  acc_size_e       sz;
  logic [2:0]      off;
  logic [7:0]      strb_c;
  logic [63:0]     wdata_c;
  logic [63:0]     aligned;

  assign ls_ok = ls_legal(regM_i_ls_info);
  assign sz    = ls_size(regM_i_ls_info);

`ifdef MEM_MISALIGN_TRAP_EN
  logic misal;
  assign off   = regM_i_alu_result[2:0];
  assign misal = ls_misaligned(sz, off);
`else
  assign off   = align_off(sz, regM_i_alu_result[2:0]);
`endif

  always_comb begin
    strb_c  = 8'h00;
    wdata_c = regM_i_regdata2;
    case (sz)
      SZ_B: begin
        strb_c  = 8'h01 << off;
        wdata_c = {8{regM_i_regdata2[7:0]}};
      end
      SZ_H: begin
        strb_c  = 8'h03 << off;
        wdata_c = {4{regM_i_regdata2[15:0]}};
      end
      SZ_W: begin
        strb_c  = 8'h0F << off;
        wdata_c = {2{regM_i_regdata2[31:0]}};
      end
      default: begin
        strb_c  = 8'hFF;
        wdata_c = regM_i_regdata2;
      end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (ls_ok) begin
`ifdef MEM_MISALIGN_TRAP_EN
          state_nxt = misal ? ST_DONE : ST_REQ;
`else
          state_nxt = ST_REQ;
`endif
        end
      end
      ST_REQ:  if (dbus_req_ready) state_nxt = ST_WAIT;
      ST_WAIT: if (dbus_resp_valid) state_nxt = ST_DONE;
      ST_DONE: if (!ext_hold_i) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign dbus_req_valid = (state == ST_REQ);
  // Stall rises in the same IDLE cycle the access is seen so EX/MEM holds it.
  assign mem_o_stall    = ((state == ST_IDLE) && ls_ok) || (state == ST_REQ) || (state == ST_WAIT);

  load_align u_load_align (
    .raw      (dbus_resp_rdata),
    .offset   (off_r),
    .load_sel (ls_r[LS_LWU:LS_LB]),
    .result   (aligned)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      ls_r           <= '0;
      off_r          <= '0;
      dbus_req_addr  <= '0;
      dbus_req_wen   <= 1'b0;
      dbus_req_wdata <= '0;
      dbus_req_wstrb <= '0;
      mem_o_rdata    <= '0;
      mem_o_done     <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mem_o_misalign <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      // Pulse only on entry so a held DONE does not report completion twice.
      mem_o_done <= (state != ST_DONE) && (state_nxt == ST_DONE);
`ifdef MEM_MISALIGN_TRAP_EN
      mem_o_misalign <= (state == ST_IDLE) && (state_nxt == ST_DONE);
`endif
      if ((state == ST_IDLE) && (state_nxt == ST_REQ)) begin
        ls_r           <= regM_i_ls_info;
        off_r          <= off;
        dbus_req_addr  <= {regM_i_alu_result[ADDR_W-1:3], 3'b000};
        dbus_req_wen   <= ls_is_store(regM_i_ls_info);
        dbus_req_wdata <= wdata_c;
        dbus_req_wstrb <= ls_is_store(regM_i_ls_info) ? strb_c : 8'h00;
      end
      if ((state == ST_WAIT) && dbus_resp_valid && !ls_is_store(ls_r))
        mem_o_rdata <= aligned;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
//
// Purpose: drives loads/stores, models the bus, checks requests and results.
// Ports: none. Honors MEM_MISALIGN_TRAP_EN like the design.

module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] ls_info;
  logic [63:0] regdata2;
  logic [63:0] alu_result;
  logic        ext_hold;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic        req_wen;
  logic [63:0] req_wdata;
  logic [7:0]  req_wstrb;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        stall;
  logic [63:0] rdata;
  logic        done;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misalign;
`endif

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk               (clk),
    .rst               (rst),
    .regM_i_ls_info    (ls_info),
    .regM_i_regdata2   (regdata2),
    .regM_i_alu_result (alu_result),
    .ext_hold_i        (ext_hold),
    .dbus_req_valid    (req_valid),
    .dbus_req_ready    (req_ready),
    .dbus_req_addr     (req_addr),
    .dbus_req_wen      (req_wen),
    .dbus_req_wdata    (req_wdata),
    .dbus_req_wstrb    (req_wstrb),
    .dbus_resp_valid   (resp_valid),
    .dbus_resp_rdata   (resp_rdata),
    .mem_o_stall       (stall),
    .mem_o_rdata       (rdata),
    .mem_o_done        (done)
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    .mem_o_misalign    (misalign)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [63:0] addr;
    logic        wen;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] rdata;
  } exp_t;

  exp_t        sb_q[$];
  logic [63:0] cur_rdata;
  int          hs_cnt = 0;
  int          done_cnt = 0;

  always @(posedge clk) begin
    if (req_valid && req_ready) hs_cnt++;
    if (done) done_cnt++;
  end

  function automatic int nbytes(input logic [10:0] ls);
    if (ls[LS_LD] | ls[LS_SD]) return 8;
    if (ls[LS_LW] | ls[LS_LWU] | ls[LS_SW]) return 4;
    if (ls[LS_LH] | ls[LS_LHU] | ls[LS_SH]) return 2;
    return 1;
  endfunction

  // Byte-lane reference model of one access.
  function automatic exp_t model(input logic [10:0] ls, input logic [63:0] d,
                                 input logic [63:0] a, input logic [63:0] raw,
                                 input logic [63:0] prev);
    exp_t e;
    int   n;
    int   o;
    logic st;
    logic [63:0] v;
    n = nbytes(ls);
    o = int'(a[2:0]);
    o = o - (o % n);
    st = |ls[10:7];
    e.addr  = {a[63:3], 3'b000};
    e.wen   = st;
    e.wstrb = 8'h00;
    e.wdata = '0;
    for (int b = 0; b < 8; b++) begin
      if (st && b >= o && b < o + n) e.wstrb[b] = 1'b1;
      e.wdata[8*b +: 8] = d[8*(b % n) +: 8];
    end
    if (st) begin
      e.rdata = prev;
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = raw[8*(o+i) +: 8];
      if ((ls[LS_LB] | ls[LS_LH] | ls[LS_LW]) && v[8*n-1])
        for (int i = 8*n; i < 64; i++) v[i] = 1'b1;
      e.rdata = v;
    end
    return e;
  endfunction

  task automatic access(input logic [10:0] ls, input logic [63:0] d, input logic [63:0] a,
                        input logic [63:0] raw, input int lat, input bit hold);
    exp_t e;
    int   k;
    int   vcnt;
    int   hs0;
    logic [63:0] a0;
    logic [63:0] w0;
    @(negedge clk);
    ls_info = ls; regdata2 = d; alu_result = a; ext_hold = hold;
    sb_q.push_back(model(ls, d, a, raw, cur_rdata));
    hs0 = hs_cnt;
    #1 check("stall_issue", stall, 1'b1);
    @(negedge clk);
    k = 0;
    while (!req_valid && k < 20) begin @(negedge clk); k++; end
    if (!req_valid) begin
      check("req_timeout", 0, 1);
      void'(sb_q.pop_front());
      ls_info = '0;
      return;
    end
    e = sb_q.pop_front();
    check("req_addr", req_addr, e.addr);
    check("req_wen", req_wen, e.wen);
    check("req_wstrb", req_wstrb, e.wstrb);
    if (e.wen) check("req_wdata", req_wdata, e.wdata);
    a0 = req_addr; w0 = req_wdata; vcnt = 1;
    for (int i = 0; i < lat; i++) begin
      @(negedge clk);
      if (req_valid) vcnt++;
      check("addr_stable", req_addr, a0);
      check("wdata_stable", req_wdata, w0);
    end
    check("valid_cycles", vcnt, lat + 1);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    check("valid_drop", req_valid, 1'b0);
    check("stall_wait", stall, 1'b1);
    check("one_handshake", hs_cnt - hs0, 1);
    @(negedge clk);
    check("stall_wait2", stall, 1'b1);
    resp_valid = 1'b1; resp_rdata = raw;
    @(negedge clk);
    resp_valid = 1'b0; resp_rdata = {$urandom, $urandom};
    check("done", done, 1'b1);
    check("stall_done", stall, 1'b0);
    check("rdata", rdata, e.rdata);
    cur_rdata = e.rdata;
    if (hold) begin
      @(negedge clk);
      check("hold_done", done, 1'b0);
      check("hold_stall", stall, 1'b0);
      check("hold_noreq", req_valid, 1'b0);
      check("hold_rdata", rdata, cur_rdata);
      ext_hold = 1'b0;
    end
    ls_info = '0;
    @(negedge clk);
    check("done_clear", done, 1'b0);
    check("idle_stall", stall, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] ls;
    logic [63:0] a;
    int          n;
    int          dcnt0;
    int          hs0;
    rst = 1'b1; ls_info = '0; regdata2 = '0; alu_result = '0; ext_hold = 1'b0;
    req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0; cur_rdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_valid", req_valid, 1'b0);
    check("rst_wen", req_wen, 1'b0);
    check("rst_wstrb", req_wstrb, 8'h00);
    check("rst_addr", req_addr, 64'h0);
    check("rst_wdata", req_wdata, 64'h0);
    check("rst_stall", stall, 1'b0);
    check("rst_rdata", rdata, 64'h0);
    check("rst_done", done, 1'b0);

    access(11'(1) << LS_LW,  64'h0, 64'h1004, 64'h8000_0001_1234_5678, 0, 1'b0);
    check("lw_value", rdata, 64'hFFFF_FFFF_8000_0001);
    access(11'(1) << LS_LBU, 64'h0, 64'h2007, 64'hF011_2233_4455_6677, 1, 1'b0);
    check("lbu_value", rdata, 64'h0000_0000_0000_00F0);
    access(11'(1) << LS_LB,  64'h0, 64'h2007, 64'hF011_2233_4455_6677, 0, 1'b1);
    check("lb_value", rdata, 64'hFFFF_FFFF_FFFF_FFF0);
    access(11'(1) << LS_SH,  64'h1234, 64'h3002, 64'h0, 0, 1'b0);
    check("sh_keeps_rdata", rdata, 64'hFFFF_FFFF_FFFF_FFF0);
    access(11'(1) << LS_SD,  64'hDEAD_BEEF_0BAD_F00D, 64'h4008, 64'h0, 3, 1'b0);

    // Randomized naturally aligned accesses (valid in both builds).
    for (int i = 0; i < 8; i++) begin
      ls = 11'(1) << $urandom_range(10, 0);
      n  = nbytes(ls);
      a  = {$urandom, $urandom};
      a[2:0] = 3'(($urandom_range(7, 0) / n) * n);
      access(ls, {$urandom, $urandom}, a, {$urandom, $urandom}, $urandom_range(2, 0), 1'($urandom_range(1, 0)));
    end

    // Several one-hot bits set: must be ignored.
    @(negedge clk);
    ls_info = 11'b000_0000_0101; alu_result = 64'h5000;
    #1 check("illegal_stall", stall, 1'b0);
    repeat (2) @(negedge clk);
    check("illegal_noreq", req_valid, 1'b0);
    ls_info = '0;

`ifdef MEM_MISALIGN_TRAP_EN
    @(negedge clk);
    hs0 = hs_cnt;
    ls_info = 11'(1) << LS_LW; alu_result = 64'h1006;
    #1 check("mis_stall0", stall, 1'b1);
    @(negedge clk);
    check("mis_done", done, 1'b1);
    check("mis_flag", misalign, 1'b1);
    check("mis_stall1", stall, 1'b0);
    check("mis_noreq", req_valid, 1'b0);
    check("mis_rdata", rdata, cur_rdata);
    ls_info = '0;
    @(negedge clk);
    check("mis_done_clr", done, 1'b0);
    check("mis_flag_clr", misalign, 1'b0);
    check("mis_no_hs", hs_cnt - hs0, 0);
`else
    // Without the trap the offset rounds down to the word boundary (offset 4).
    access(11'(1) << LS_LW, 64'h0, 64'h1006, 64'h8000_0001_1234_5678, 0, 1'b0);
    check("lw_round_value", rdata, 64'hFFFF_FFFF_8000_0001);
`endif

    // Reset during WAIT: a late response must not complete anything.
    @(negedge clk);
    ls_info = 11'(1) << LS_LW; alu_result = 64'h1000;
    @(negedge clk);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0; ls_info = '0;
    check("rstw_in_wait", stall, 1'b1);
    dcnt0 = done_cnt;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cur_rdata = '0;
    check("rstw_valid", req_valid, 1'b0);
    check("rstw_stall", stall, 1'b0);
    @(negedge clk);
    resp_valid = 1'b1; resp_rdata = 64'h1111_2222_3333_4444;
    @(negedge clk);
    resp_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rstw_no_done", done_cnt - dcnt0, 0);
    check("rstw_rdata", rdata, cur_rdata);
    check("rstw_stall2", stall, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
